// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: shared definitions for the HDMI pixel-domain timing slice.
//   - default 640x480@60 timing constants and total-count helpers
//   - COORD_W: width of the pixel/line counters and of x/y
//   - lock/run state enum used by hdmi_lock_sync and exposed for debug
//   - colour-bar constants for the optional test pattern
//     (HDMI_VIDEO_TIMING_TEST_PATTERN_EN)
package hdmi_video_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vt_state_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Bar index 0 is the leftmost bar.
  function automatic logic [23:0] bar_rgb(logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// hdmi_video_timing_if: video timing bundle from the timing generator to the
// TMDS encoder. All members change on clk and are mutually aligned.
//   hsync/vsync  sync pulses (polarity set by the generator's SYNC_ACTIVE)
//   de           data enable, high in the active region
//   x/y          pixel column/row, valid when de (0 otherwise)
//   frame_start  one-cycle pulse with de at x=0, y=0
//   running      generator is in RUN
//   state        lock/run state, for debug only
//   rgb          test pattern, present only with
//                HDMI_VIDEO_TIMING_TEST_PATTERN_EN
// Stream semantics: no handshake; the sink must accept one pixel per clk
// (there is no ready), de alone qualifies x/y/rgb.
interface hdmi_video_timing_if;
  import hdmi_video_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               frame_start;
  logic               running;
  vt_state_e          state;
`ifdef HDMI_VIDEO_TIMING_TEST_PATTERN_EN
  logic [23:0]        rgb;

  modport master (output hsync, vsync, de, x, y, frame_start, running, state, rgb);
  modport slave  (input  hsync, vsync, de, x, y, frame_start, running, state, rgb);
`else
  modport master (output hsync, vsync, de, x, y, frame_start, running, state);
  modport slave  (input  hsync, vsync, de, x, y, frame_start, running, state);
`endif

endinterface

// File: rtl/hdmi_lock_sync.sv
// hdmi_lock_sync: qualifies an asynchronous PLL lock for one clock domain.
//   clk, rst_n  domain clock, asynchronous active-low reset
//   locked      raw PLL lock (asynchronous to clk)
//   lock_ok     high while in RUN and the synchronized lock is still high
//   state       WAIT_LOCK / SETTLE / RUN, for debug
// Lock goes through a 2-flop synchronizer; RUN is entered only after
// SETTLE_CYCLES consecutive cycles of synchronized lock. Any low sample in
// SETTLE or RUN drops back to WAIT_LOCK and restarts the full settle.
module hdmi_lock_sync
  import hdmi_video_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      locked,
  output logic      lock_ok,
  output vt_state_e state
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                lock_meta;
  logic                lock_s;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_cnt_nxt;
  vt_state_e           state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      lock_meta  <= locked;
      lock_s     <= lock_meta;
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // The settle count is only kept while counting up in SETTLE; every other
  // path (including the exit to RUN) leaves it cleared.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = '0;
    case (state)
      WAIT_LOCK: if (lock_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!lock_s)                       state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
        else                               settle_cnt_nxt = settle_cnt + 1'b1;
      end
      RUN:     if (!lock_s) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Gating with lock_s lets the timing counters clear on the same edge that
  // the state machine leaves RUN.
  assign lock_ok = (state == RUN) && lock_s;

endmodule

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: 640x480@60 (by default) pixel-domain timing generator.
//   clk     pixel clock (25.2 MHz from the HDMI PLL)
//   rst_n   asynchronous active-low reset
//   locked  PLL lock, asynchronous to clk
//   vid     hdmi_video_timing_if master: hsync, vsync, de, x, y,
//           frame_start, running, state (+ rgb with the test pattern)
// Optional feature macro: HDMI_VIDEO_TIMING_TEST_PATTERN_EN adds an 8-bar
// colour test pattern on vid.rgb.
// Outputs are registered one cycle after the counter state they describe and
// are forced to their idle values whenever the lock is not qualified.
module hdmi_video_timing
  import hdmi_video_pkg::*;
#(
  parameter int   H_ACTIVE      = DEF_H_ACTIVE,
  parameter int   H_FP          = DEF_H_FP,
  parameter int   H_SYNC        = DEF_H_SYNC,
  parameter int   H_BP          = DEF_H_BP,
  parameter int   V_ACTIVE      = DEF_V_ACTIVE,
  parameter int   V_FP          = DEF_V_FP,
  parameter int   V_SYNC        = DEF_V_SYNC,
  parameter int   V_BP          = DEF_V_BP,
  parameter logic SYNC_ACTIVE   = 1'b0,
  parameter int   SETTLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked,
  hdmi_video_timing_if.master vid
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_L   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_L   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic               lock_ok;
  vt_state_e          lock_state;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               de_c;
  logic               hs_c;
  logic               vs_c;

  hdmi_lock_sync #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .locked  (locked),
    .lock_ok (lock_ok),
    .state   (lock_state)
  );

  assign vid.state = lock_state;

  // Counters sit at 0 outside RUN, so RUN always begins at the top-left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!lock_ok) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign de_c = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign hs_c = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  // v_cnt only moves when h_cnt wraps, so vsync switches at h_cnt = 0.
  assign vs_c = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

`ifdef HDMI_VIDEO_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;

  // Threshold compare instead of a divider: the last bar boundary passed wins.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= COORD_W'(i * BAR_W)) bar_idx = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hsync       <= ~SYNC_ACTIVE;
      vid.vsync       <= ~SYNC_ACTIVE;
      vid.de          <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.frame_start <= 1'b0;
      vid.running     <= 1'b0;
`ifdef HDMI_VIDEO_TIMING_TEST_PATTERN_EN
      vid.rgb         <= '0;
`endif
    end else if (!lock_ok) begin
      vid.hsync       <= ~SYNC_ACTIVE;
      vid.vsync       <= ~SYNC_ACTIVE;
      vid.de          <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.frame_start <= 1'b0;
      vid.running     <= 1'b0;
`ifdef HDMI_VIDEO_TIMING_TEST_PATTERN_EN
      vid.rgb         <= '0;
`endif
    end else begin
      vid.hsync       <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vid.vsync       <= vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vid.de          <= de_c;
      vid.x           <= de_c ? h_cnt : '0;
      vid.y           <= de_c ? v_cnt : '0;
      vid.frame_start <= de_c && (h_cnt == '0) && (v_cnt == '0);
      vid.running     <= 1'b1;
`ifdef HDMI_VIDEO_TIMING_TEST_PATTERN_EN
      vid.rgb         <= de_c ? bar_rgb(bar_idx) : '0;
`endif
    end
  end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
Pixel-domain timing generator driven by the 25.2 MHz pixel clock from the HDMI PLL. Produces 640x480@60 hsync/vsync/data-enable and pixel coordinates for the downstream TMDS encoder and serializer. Gates video start on a synchronized, settled PLL lock. Blanks all outputs whenever lock is lost.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch in lines
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = negative polarity)
SETTLE_CYCLES, 1024, pixel clocks of stable lock required before RUN (>=1)

Ports:
clk  in  1  pixel clock, 25.2 MHz (PLL CLKOS)
rst_n  in  1  asynchronous active-low reset
locked  in  1  PLL lock, asynchronous to clk
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable, high in the active region
x  out  10  pixel column, valid when de
y  out  10  pixel row, valid when de
frame_start  out  1  one-cycle pulse with de at x=0, y=0
running  out  1  high in the RUN state
rgb  out  24  test pattern (only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all flops clear. hsync = vsync = ~SYNC_ACTIVE (inactive level). de = 0, x = 0, y = 0, frame_start = 0, running = 0, rgb = 0. State = WAIT_LOCK.
- Lock synchronizer: locked passes through a 2-flop synchronizer to produce lock_s.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter widths: h_cnt and v_cnt are 10 bits. Elaboration check: H_TOTAL <= 1024 and V_TOTAL <= 1024.
- State WAIT_LOCK:
  - settle count, h_cnt and v_cnt held at 0; outputs at reset values.
  - lock_s = 1 -> SETTLE.
- State SETTLE:
  - settle count increments each cycle; outputs at reset values.
  - lock_s = 0 -> WAIT_LOCK, with settle count cleared.
  - settle count == SETTLE_CYCLES-1 -> RUN, with h_cnt = v_cnt = 0.
- State RUN:
  - h_cnt increments each cycle and wraps at H_TOTAL-1 to 0.
  - v_cnt increments on every h_cnt wrap and wraps at V_TOTAL-1 to 0.
  - lock_s = 0 -> WAIT_LOCK. On the same edge, counters clear and outputs return to reset values. No partial-frame completion.
- Output decode (registered, one cycle after the counter state they describe):
  - de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hsync = SYNC_ACTIVE when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync = SYNC_ACTIVE when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vsync changes on the line boundary, aligned with h_cnt = 0.
  - x = h_cnt and y = v_cnt whenever de is high; both are 0 whenever de is low.
  - frame_start = de and x == 0 and y == 0.
  - running = registered (state == RUN).
  - hsync, vsync, de, x, y, frame_start and rgb are mutually aligned in the same cycle.
- Startup latency: with locked rising before edge 1, de first reads 1 after rising edge SETTLE_CYCLES+4. frame_start fires on that same cycle.
- Lock glitches: a glitch shorter than the synchronizer delay may be missed. Any lock_s low sampled in SETTLE or RUN restarts the full settle sequence.
- Reset mid-frame: immediate asynchronous return to reset values and WAIT_LOCK.

Optional Feature:
Macro HDMI_VIDEO_TIMING_TEST_PATTERN_EN.
- Defined:
  - rgb carries 8 vertical colour bars, each H_ACTIVE/8 wide. Bar index = x[9:0] / 80 for the default parameters.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Colour channels are 8'hFF or 8'h00. rgb = 0 whenever de = 0.
  - rgb is registered and aligned with de.
- Undefined: the rgb port is not present, and the block contains no pattern logic.

Decomposition:
- Package hdmi_video_pkg:
  - default 640x480 timing constants
  - H_TOTAL/V_TOTAL functions
  - COORD_W = 10
  - colour-bar RGB constants
  - state enum typedef (WAIT_LOCK, SETTLE, RUN)
- Sub-module hdmi_lock_sync: the 2-flop synchronizer plus the settle counter, producing a qualified lock_ok. This sub-module is reusable for the TMDS-clock domain.

Test Plan:
1. Reset with locked=1 from time 0, SETTLE_CYCLES=16 -> de first high after edge 20; frame_start pulses once on that cycle with x=0, y=0.
2. Run 2 full frames -> every frame is 420000 cycles; per line de high for 640 cycles and hsync low for 96 cycles starting 16 cycles after de falls; per frame 480 de-lines, vsync low for 2 lines (1600 cycles) starting at line 490.
3. Drop locked at line 100, x=300 -> within 3 cycles de=0, hsync=vsync=1, running=0; re-assert locked -> restart, with frame_start exactly SETTLE_CYCLES+4 edges later.
4. Pulse locked low for 1 cycle during SETTLE at count 10 -> SETTLE restarts; RUN is entered only after a full 16-cycle stable lock.
5. Assert rst_n=0 asynchronously mid-line -> all outputs reach reset values before the next clk edge.
6. With HDMI_VIDEO_TIMING_TEST_PATTERN_EN defined -> rgb=FFFFFF at x=0..79, FFFF00 at x=80, 000000 at x=560..639, and 0 during blanking.
